aes256_inv_keysched: RTL

//   Sequential AES-256 key schedule for the decryption datapath: expands a
//   256-bit cipher key forward, then walks the schedule backwards, emitting

---
 rtl/aes256_inv_keysched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/aes256_inv_keysched.sv
// rtl/aes256_inv_keysched.sv - AES-256 key schedule emitting round keys 14 down to 0
//
// Expands the 256-bit cipher key forward over 13 cycles, then walks the
// schedule backwards using a two-round-key window, handing out one round key
// per rk_valid/rk_ready handshake without storing the whole schedule.
//
// Ports:
//   clk       in   1    clock, rising edge
//   rst       in   1    asynchronous, active-high reset
//   start     in   1    1-cycle request, samples key
//   key       in   256  cipher key, key[255:224] = w0 ... key[31:0] = w7
//   busy      out  1    high while expanding or emitting
//   rk_valid  out  1    rk_data/rk_idx hold a round key
//   rk_ready  in   1    consumer accepts when rk_valid & rk_ready
//   rk_data   out  128  round key {w[4n],w[4n+1],w[4n+2],w[4n+3]}
//   rk_idx    out  4    round number n of rk_data
//   rk_last   out  1    rk_valid & (rk_idx == 0)
module aes256_inv_keysched #(
    parameter int ALLOW_RESTART = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_last
);

    localparam bit RESTART_EN = (ALLOW_RESTART != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_EMIT
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] a_q, a_d;
    logic [127:0] b_q, b_d;
    logic [3:0]   n_q, n_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    // Single g() shared by both directions: forward uses B.w3, backward A.w3.
    logic [31:0] g_in, sb_in, sb_out, g_out;
    logic [7:0]  rc;

    always_comb begin
        g_in   = (state_q == S_EMIT) ? a_q[31:0] : b_q[31:0];
        sb_in  = n_q[0] ? g_in : {g_in[23:0], g_in[31:24]};
        sb_out = {sbox(sb_in[31:24]), sbox(sb_in[23:16]),
                  sbox(sb_in[15:8]),  sbox(sb_in[7:0])};
        case (n_q[3:1])
            3'd1:    rc = 8'h01;
            3'd2:    rc = 8'h02;
            3'd3:    rc = 8'h04;
            3'd4:    rc = 8'h08;
            3'd5:    rc = 8'h10;
            3'd6:    rc = 8'h20;
            3'd7:    rc = 8'h40;
            default: rc = 8'h00;
        endcase
        g_out = n_q[0] ? sb_out : (sb_out ^ {rc, 24'h0});
    end

    // Forward step: rk(n) from rk(n-2)=A, rk(n-1)=B.
    logic [31:0] e0, e1, e2, e3;
    // Backward step: rk(n-2) from rk(n-1)=A, rk(n)=B.
    logic [31:0] p0, p1, p2, p3;

    always_comb begin
        e0 = a_q[127:96] ^ g_out;
        e1 = a_q[95:64] ^ e0;
        e2 = a_q[63:32] ^ e1;
        e3 = a_q[31:0] ^ e2;
        p3 = b_q[31:0] ^ b_q[63:32];
        p2 = b_q[63:32] ^ b_q[95:64];
        p1 = b_q[95:64] ^ b_q[127:96];
        p0 = b_q[127:96] ^ g_out;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = key[255:128];
                    b_d     = key[127:0];
                    n_d     = 4'd2;
                    state_d = S_EXPAND;
                end
            end
            S_EXPAND: begin
                a_d = b_q;
                b_d = {e0, e1, e2, e3};
                if (n_q == 4'd14) begin
                    state_d = S_EMIT;
                end else begin
                    n_d = n_q + 4'd1;
                end
            end
            S_EMIT: begin
                if (RESTART_EN && start) begin
                    a_d     = key[255:128];
                    b_d     = key[127:0];
                    n_d     = 4'd2;
                    state_d = S_EXPAND;
                end else if (rk_ready) begin
                    if (n_q == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        // At n==1 the value shifted into A is never emitted.
                        b_d = a_q;
                        a_d = {p0, p1, p2, p3};
                        n_d = n_q - 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign rk_valid = (state_q == S_EMIT);
    assign rk_data  = rk_valid ? b_q : '0;
    assign rk_idx   = rk_valid ? n_q : '0;
    assign rk_last  = rk_valid && (n_q == 4'd0);

endmodule
